// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline definitions: ResultSrc encodings, load/store funct3
// codes and the load/store unit state type.
package riscv_pkg;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } lsu_state_t;

  // Undefined encodings (011, 110, 111) fall through to word accesses.
  function automatic logic is_byte_access(input logic [2:0] funct3);
    return funct3[1:0] == 2'b00;
  endfunction

  function automatic logic is_half_access(input logic [2:0] funct3);
    return funct3[1:0] == 2'b01;
  endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Combinational load-data lane select with sign/zero extension; shared by
// the M-stage bus path and any later cache read path.
module lsu_load_ext
  import riscv_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[8*addr_lo +: 8];
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   data = {24'h0, byte_sel};
      F3_H:    data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   data = {16'h0, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// M-stage load/store unit: bus request/stall FSM with wait-cycle timeout.
// Optional misaligned-access trap is enabled by defining MISALIGN_TRAP_EN.
module mem_stage_lsu
  import riscv_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        BusErrM,
  output logic        MisalignM
);

  localparam logic [31:0] LIMIT = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

  lsu_state_t  state, next_state;
  logic [31:0] wait_cnt;
  logic        active, misalign, go, timeout_hit;
  logic        byte_acc, half_acc;
  logic [31:0] load_data;

  lsu_load_ext u_load_ext (
    .rdata   (mem_rdata),
    .addr_lo (ALUResultM[1:0]),
    .funct3  (funct3M),
    .data    (load_data)
  );

  // Outputs are gated by rst_n so an asserted reset drops the request at once.
  always_comb begin
    byte_acc = is_byte_access(funct3M);
    half_acc = is_half_access(funct3M);
    active   = MemWriteM || (ResultSrcM == RES_MEM);
`ifdef MISALIGN_TRAP_EN
    misalign = half_acc ? ALUResultM[0] : (!byte_acc && (ALUResultM[1:0] != 2'b00));
`else
    misalign = 1'b0;
`endif
    go          = rst_n && active && !misalign;
    timeout_hit = (TIMEOUT != 0) && (wait_cnt == LIMIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wait_cnt <= 32'd0;
    end else begin
      state    <= next_state;
      wait_cnt <= (next_state == WAIT) ? wait_cnt + 32'd1 : 32'd0;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (go && !mem_ready && !timeout_hit) next_state = WAIT;
      WAIT: if (!go || mem_ready || timeout_hit) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 32'h0;
    mem_be    = 4'h0;
    mem_wdata = 32'h0;
    ReadDataM = 32'h0;
    StallM    = 1'b0;
    BusErrM   = 1'b0;
    MisalignM = rst_n && active && misalign;
    if (go) begin
      mem_req  = 1'b1;
      mem_we   = MemWriteM;
      mem_addr = {ALUResultM[31:2], 2'b00};
      if (MemWriteM) begin
        if (byte_acc) begin
          mem_be    = 4'b0001 << ALUResultM[1:0];
          mem_wdata = {4{WriteDataM[7:0]}};
        end else if (half_acc) begin
          mem_be    = ALUResultM[1] ? 4'b1100 : 4'b0011;
          mem_wdata = {2{WriteDataM[15:0]}};
        end else begin
          mem_be    = 4'b1111;
          mem_wdata = WriteDataM;
        end
      end else begin
        mem_be = 4'b1111;
      end
      if (mem_ready) begin
        if (!MemWriteM) ReadDataM = load_data;
      end else if (timeout_hit) begin
        BusErrM = 1'b1;
      end else begin
        StallM = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed, table-driven bench for mem_stage_lsu (default TIMEOUT of 16),
// plus hand-written wait, timeout and reset sequences.
module tb_mem_stage_lsu;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [2:0]  funct3M;
  logic [31:0] ALUResultM, WriteDataM;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata, ReadDataM;
  logic        StallM, BusErrM, MisalignM;

  mem_stage_lsu dut (
    .clk(clk), .rst_n(rst_n), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .funct3M(funct3M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .ReadDataM(ReadDataM), .StallM(StallM), .BusErrM(BusErrM), .MisalignM(MisalignM)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        mw;
    logic [1:0]  rs;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        ready;
    logic [31:0] rdata;
  } in_t;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdm;
    logic        stall;
    logic        buserr;
    logic        mis;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs [NVEC];
  int checks = 0;
  int errors = 0;

  function automatic in_t mkIn(logic mw, logic [1:0] rs, logic [2:0] f3, logic [31:0] addr,
                               logic [31:0] wd, logic ready, logic [31:0] rdata);
    in_t v;
    v.mw = mw; v.rs = rs; v.f3 = f3; v.addr = addr; v.wd = wd; v.ready = ready; v.rdata = rdata;
    return v;
  endfunction

  function automatic out_t mkOut(logic req, logic we, logic [31:0] addr, logic [3:0] be,
                                 logic [31:0] wdata, logic [31:0] rdm, logic stall,
                                 logic buserr, logic mis);
    out_t o;
    o.req = req; o.we = we; o.addr = addr; o.be = be; o.wdata = wdata; o.rdm = rdm;
    o.stall = stall; o.buserr = buserr; o.mis = mis;
    return o;
  endfunction

  task automatic applyStimulus(input in_t v);
    MemWriteM  = v.mw;
    ResultSrcM = v.rs;
    funct3M    = v.f3;
    ALUResultM = v.addr;
    WriteDataM = v.wd;
    mem_ready  = v.ready;
    mem_rdata  = v.rdata;
  endtask

  task automatic checkOutput(input string tag, input out_t exp);
    out_t act;
    act = mkOut(mem_req, mem_we, mem_addr, mem_be, mem_wdata, ReadDataM, StallM, BusErrM, MisalignM);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got req=%b we=%b addr=%h be=%b wdata=%h rdata=%h stall=%b err=%b mis=%b, expected req=%b we=%b addr=%h be=%b wdata=%h rdata=%h stall=%b err=%b mis=%b",
               tag, act.req, act.we, act.addr, act.be, act.wdata, act.rdm, act.stall, act.buserr, act.mis,
               exp.req, exp.we, exp.addr, exp.be, exp.wdata, exp.rdm, exp.stall, exp.buserr, exp.mis);
    end
  endtask

  task automatic checkVal(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  // Entered and left on a negedge; mem_ready rises in cycle nWaits (never if negative).
  task automatic runWait(input string tag, input in_t v, input int nWaits,
                         input logic [31:0] expData, input logic expErr, input int expStalls);
    int stalls = 0;
    bit done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      v.ready = (c == nWaits);
      applyStimulus(v);
      #1;
      if (StallM === 1'b1) begin
        stalls++;
      end else begin
        done = 1;
        checkVal({tag, " data"}, ReadDataM, expData);
        checkVal({tag, " buserr"}, 32'(BusErrM), 32'(expErr));
      end
      @(negedge clk);
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: stall never released within 40 cycles", tag);
    end
    checkVal({tag, " stall cycles"}, stalls, expStalls);
  endtask

  in_t  idle_in;
  out_t zero_out;

  initial begin
    idle_in  = mkIn(1'b0, RES_ALU, 3'b000, 32'h0, 32'h0, 1'b0, 32'h0);
    zero_out = mkOut(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

    vecs[0]  = '{mkIn(0, RES_ALU, F3_W, 32'h1004, 32'h11111111, 1, 32'h99999999), zero_out};
    vecs[1]  = '{mkIn(1, RES_ALU, F3_B, 32'h1003, 32'h000000A5, 1, 32'h0),
                 mkOut(1, 1, 32'h1000, 4'b1000, 32'hA5A5A5A5, 32'h0, 0, 0, 0)};
    vecs[2]  = '{mkIn(1, RES_ALU, F3_H, 32'h1002, 32'h1234BEEF, 1, 32'h0),
                 mkOut(1, 1, 32'h1000, 4'b1100, 32'hBEEFBEEF, 32'h0, 0, 0, 0)};
    vecs[3]  = '{mkIn(1, RES_ALU, F3_W, 32'h1004, 32'hDEADBEEF, 1, 32'h0),
                 mkOut(1, 1, 32'h1004, 4'b1111, 32'hDEADBEEF, 32'h0, 0, 0, 0)};
    vecs[4]  = '{mkIn(0, RES_MEM, F3_HU, 32'h2002, 32'h0, 1, 32'hBEEF1234),
                 mkOut(1, 0, 32'h2000, 4'b1111, 32'h0, 32'h0000BEEF, 0, 0, 0)};
    vecs[5]  = '{mkIn(0, RES_MEM, F3_H, 32'h2000, 32'h0, 1, 32'hBEEF8234),
                 mkOut(1, 0, 32'h2000, 4'b1111, 32'h0, 32'hFFFF8234, 0, 0, 0)};
    vecs[6]  = '{mkIn(0, RES_MEM, F3_B, 32'h2001, 32'h0, 1, 32'h00008000),
                 mkOut(1, 0, 32'h2000, 4'b1111, 32'h0, 32'hFFFFFF80, 0, 0, 0)};
    vecs[7]  = '{mkIn(0, RES_MEM, F3_BU, 32'h2003, 32'h0, 1, 32'h7F000000),
                 mkOut(1, 0, 32'h2000, 4'b1111, 32'h0, 32'h0000007F, 0, 0, 0)};
    vecs[8]  = '{mkIn(0, RES_MEM, F3_W, 32'h2004, 32'h0, 1, 32'h12345678),
                 mkOut(1, 0, 32'h2004, 4'b1111, 32'h0, 32'h12345678, 0, 0, 0)};
    vecs[9]  = '{mkIn(0, RES_MEM, 3'b011, 32'h2008, 32'h0, 1, 32'hCAFEF00D),
                 mkOut(1, 0, 32'h2008, 4'b1111, 32'h0, 32'hCAFEF00D, 0, 0, 0)};
    vecs[10] = '{mkIn(1, RES_MEM, F3_B, 32'h1001, 32'h0000005A, 1, 32'hFFFFFFFF),
                 mkOut(1, 1, 32'h1000, 4'b0010, 32'h5A5A5A5A, 32'h0, 0, 0, 0)};
`ifdef MISALIGN_TRAP_EN
    vecs[11] = '{mkIn(0, RES_MEM, F3_W, 32'h3002, 32'h0, 1, 32'h55667788),
                 mkOut(0, 0, 32'h0, 4'h0, 32'h0, 32'h0, 0, 0, 1)};
`else
    vecs[11] = '{mkIn(0, RES_MEM, F3_W, 32'h3002, 32'h0, 1, 32'h55667788),
                 mkOut(1, 0, 32'h3000, 4'b1111, 32'h0, 32'h55667788, 0, 0, 0)};
`endif
    vecs[12] = '{mkIn(0, RES_PC4, F3_W, 32'h2000, 32'h0, 1, 32'h12345678), zero_out};
    vecs[13] = '{mkIn(1, RES_ALU, F3_B, 32'h1002, 32'h123456C3, 1, 32'h0),
                 mkOut(1, 1, 32'h1000, 4'b0100, 32'hC3C3C3C3, 32'h0, 0, 0, 0)};

    // Reset holds every output low even with an access presented.
    applyStimulus(vecs[4].i);
    @(negedge clk);
    #1;
    checkOutput("reset", zero_out);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < NVEC; k++) begin
      applyStimulus(vecs[k].i);
      #1;
      checkOutput($sformatf("vec%0d", k), vecs[k].o);
      @(negedge clk);
    end

    runWait("lb_wait3", mkIn(0, RES_MEM, F3_B, 32'h2002, 32'h0, 0, 32'h00800000),
            3, 32'hFFFFFF80, 1'b0, 3);
    runWait("lbu_wait3", mkIn(0, RES_MEM, F3_BU, 32'h2002, 32'h0, 0, 32'h00800000),
            3, 32'h00000080, 1'b0, 3);
    applyStimulus(vecs[3].i);
    #1;
    checkOutput("back_to_back", vecs[3].o);
    @(negedge clk);

    runWait("ready_at_limit", mkIn(0, RES_MEM, F3_W, 32'h2004, 32'h0, 0, 32'h11223344),
            15, 32'h11223344, 1'b0, 15);

    // Reset pulse in the second WAIT cycle.
    applyStimulus(mkIn(0, RES_MEM, F3_W, 32'h2004, 32'h0, 0, 32'h0));
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkVal("rst_mid_wait req", 32'(mem_req), 32'd0);
    checkVal("rst_mid_wait stall", 32'(StallM), 32'd0);
    checkVal("rst_mid_wait buserr", 32'(BusErrM), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    runWait("timeout", mkIn(0, RES_MEM, F3_W, 32'h2000, 32'h0, 0, 32'hAAAAAAAA),
            -1, 32'h0, 1'b1, 15);
    applyStimulus(idle_in);
    #1;
    checkOutput("after_abort", zero_out);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
